// File: rtl/night_rider_pkg.sv
// night_rider_pkg: shared opcodes, FSM states and scan modes for the night-rider scanner.
package night_rider_pkg;
  localparam logic [2:0] OP_START_CONT  = 3'd1;
  localparam logic [2:0] OP_START_SWEEP = 3'd2;
  localparam logic [2:0] OP_PAUSE       = 3'd3;
  localparam logic [2:0] OP_RESUME      = 3'd4;
  localparam logic [2:0] OP_STOP        = 3'd5;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSED} state_e;
  typedef enum logic {MODE_CONT, MODE_SWEEP} mode_e;
endpackage

// File: rtl/nr_step_timer.sv
// nr_step_timer: tick counter that flags the last cycle of each step period.
module nr_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);
  logic [PERIOD_W-1:0] tick_q, tick_d;
  assign step = tick_q == period - PERIOD_W'(1);
  always_comb tick_d = clr ? '0 : en ? (step ? '0 : tick_q + PERIOD_W'(1)) : tick_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) tick_q <= '0;
    else tick_q <= tick_d;
endmodule

// File: rtl/night_rider_scan_ctrl.sv
// night_rider_scan_ctrl: command-driven bouncing one-hot LED sequencer with
// continuous and single-sweep modes.
module night_rider_scan_ctrl
  import night_rider_pkg::*;
#(
  parameter int N        = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [PERIOD_W-1:0]  cmd_period,
  output logic                 cmd_ready,
  output logic                 cmd_err,
  output logic [N-1:0]         led_out,
  output logic [$clog2(N)-1:0] pos,
  output logic                 dir,
  output logic                 step,
  output logic                 busy,
  output logic                 sweep_done
);
  localparam int POS_W = $clog2(N);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_nx;
  logic dir_q, dir_d, err_q, done_q;
  logic accept, is_start, legal, adv, fin, restart, clr, en, tmr_step;
  nr_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .period(period_q), .step(tmr_step)
  );
  // a legal command in the same cycle as a step wins: pos holds, no sweep completion
  always_comb begin
    cmd_ready = state_q != ST_LOAD;
    accept = cmd_valid && cmd_ready;
    is_start = cmd_op == OP_START_CONT || cmd_op == OP_START_SWEEP;
    legal = accept && (is_start || (cmd_op == OP_PAUSE && state_q == ST_RUN) ||
            (cmd_op == OP_RESUME && state_q == ST_PAUSED) || (cmd_op == OP_STOP && state_q != ST_IDLE));
    step = state_q == ST_RUN && tmr_step;
    adv = step && !legal;
    pos_nx = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    fin = adv && mode_q == MODE_SWEEP && !dir_q && pos_nx == '0;
    restart = (legal && (is_start || cmd_op == OP_STOP)) || fin;
    state_d = legal ? (is_start ? ST_LOAD : cmd_op == OP_PAUSE ? ST_PAUSED : cmd_op == OP_RESUME ? ST_RUN : ST_IDLE)
            : fin ? ST_IDLE : state_q == ST_LOAD ? ST_RUN : state_q;
    mode_d = (legal && is_start) ? (cmd_op == OP_START_SWEEP ? MODE_SWEEP : MODE_CONT) : mode_q;
    period_d = (legal && is_start) ? (cmd_period == '0 ? PERIOD_W'(1) : cmd_period) : period_q;
    pos_d = restart ? '0 : adv ? pos_nx : pos_q;
    dir_d = restart ? 1'b1 : adv ? (pos_nx == POS_W'(N - 1) ? 1'b0 : pos_nx == '0 ? 1'b1 : dir_q) : dir_q;
    clr = state_d != state_q && state_d != ST_PAUSED;
    en = state_q == ST_RUN && state_d == ST_RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_CONT;
      period_q <= PERIOD_W'(1);
      pos_q    <= '0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      err_q    <= accept && !legal;
      done_q   <= fin;
    end
  assign busy       = state_q != ST_IDLE;
  assign led_out    = busy ? N'(1) << pos_q : '0;
  assign pos        = pos_q;
  assign dir        = dir_q;
  assign cmd_err    = err_q;
  assign sweep_done = done_q;
endmodule

// File: tb/tb_night_rider_scan_ctrl.sv
// tb_night_rider_scan_ctrl: directed and random commands checked against a
// step-count model of the bounce sequence.
module tb_night_rider_scan_ctrl;
  localparam int N = 8, PW = 16, L = 2 * N - 2;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic [2:0] cmd_op = 0;
  logic [PW-1:0] cmd_period = 0;
  logic cmd_ready, cmd_err, dir, step, busy, sweep_done;
  logic [N-1:0] led_out;
  logic [$clog2(N)-1:0] pos;
  int vecs = 0, errs = 0;
  int ms = 0, mk = 0, mt = 0, mp = 1;
  bit msw = 0, merr = 0, mdone = 0;
  always #5 clk = ~clk;
  night_rider_scan_ctrl #(.N(N), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_period(cmd_period),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .led_out(led_out), .pos(pos), .dir(dir),
    .step(step), .busy(busy), .sweep_done(sweep_done)
  );
  // model state: ms 0 idle/1 load/2 run/3 paused, mk steps since start, mt cycles since last step
  function automatic int epos();
    int ph = mk % L;
    return ph < N ? ph : L - ph;
  endfunction
  function automatic bit edir();
    return (mk % L) < N - 1;
  endfunction
  function automatic bit estep();
    return ms == 2 && mt == mp - 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    logic [N-1:0] el;
    el = ms != 0 ? N'(1) << epos() : '0;
    chk("led_out", 32'(led_out), 32'(el));
    chk("pos", 32'(pos), 32'(epos()));
    chk("dir", 32'(dir), 32'(edir()));
    chk("busy", 32'(busy), 32'(ms != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'(ms != 1));
    chk("step", 32'(step), 32'(estep()));
    chk("cmd_err", 32'(cmd_err), 32'(merr));
    chk("sweep_done", 32'(sweep_done), 32'(mdone));
  endtask
  task automatic mreset();
    ms = 0; mk = 0; mt = 0; mp = 1; msw = 0; merr = 0; mdone = 0;
  endtask
  task automatic cyc(input bit v, input logic [2:0] op, input logic [PW-1:0] per);
    bit st, acc, lg;
    check_all();
    cmd_valid = v; cmd_op = op; cmd_period = per;
    st = estep();
    acc = v && ms != 1;
    lg = acc && (op == 1 || op == 2 || (op == 3 && ms == 2) || (op == 4 && ms == 3) || (op == 5 && ms != 0));
    merr = acc && !lg;
    mdone = 0;
    if (lg) begin
      if (op == 1 || op == 2) begin
        ms = 1; mk = 0; mt = 0; mp = per == 0 ? 1 : int'(per); msw = op == 2;
      end else if (op == 3) ms = 3;
      else if (op == 4) begin ms = 2; mt = 0; end
      else begin ms = 0; mk = 0; end
    end else if (st) begin
      mk++; mt = 0;
      if (msw && mk == L) begin ms = 0; mk = 0; mdone = 1; end
    end else if (ms == 2) mt++;
    else if (ms == 1) begin ms = 2; mt = 0; end
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 3'd0, '0);
  endtask
  task automatic do_reset();
    rst = 1; mreset();
    repeat (3) begin @(posedge clk); #1; check_all(); end
    rst = 0;
  endtask
  initial begin
    do_reset();
    cyc(1, 3'd1, 16'd2); idle(40);
    cyc(1, 3'd2, 16'd1); idle(20);
    cyc(1, 3'd1, 16'd3);
    for (int i = 0; i < 200 && !(estep() && epos() == 5); i++) cyc(0, 3'd0, '0);
    chk("pause_pos5_step", 32'(step), 32'd1);
    chk("pause_pos5_pos", 32'(pos), 32'd5);
    cyc(1, 3'd3, '0); idle(20);
    cyc(1, 3'd4, '0); idle(8);
    cyc(1, 3'd1, 16'd1);
    for (int i = 0; i < 200 && !(epos() == 3 && !edir()); i++) cyc(0, 3'd0, '0);
    chk("stop_dir_down", 32'(dir), 32'd0);
    cyc(1, 3'd5, '0); idle(3);
    cyc(1, 3'd2, 16'd2); idle(9);
    #2 rst = 1; mreset();
    #1 check_all();
    @(posedge clk); #1; check_all();
    rst = 0; idle(2);
    cyc(1, 3'd4, '0); idle(2);
    cyc(1, 3'd3, '0); cyc(1, 3'd5, '0); cyc(1, 3'd0, '0); cyc(1, 3'd6, '0); idle(1);
    cyc(1, 3'd1, 16'd50); idle(3);
    cyc(1, 3'd7, '0); idle(3);
    cyc(1, 3'd1, 16'd0); idle(20);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), PW'($urandom_range(0, 4)));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
